// File: rtl/doc5503_wave_arbiter.sv
// Sound RAM arbiter between DOC5503 wave fetches and host (GLU) accesses.
// One access at a time via IDLE/ISSUE/WAIT/DONE; DOC has priority, bounded by a host starvation guard.
module doc5503_wave_arbiter #(
  parameter int unsigned ADDR_WIDTH    = 16,
  parameter int unsigned RAM_LATENCY   = 2,
  parameter int unsigned HOST_MAX_WAIT = 8
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic [ADDR_WIDTH-1:0] doc_addr_i,
  input  logic                  doc_rd_i,
  output logic                  doc_ready_o,
  output logic [7:0]            doc_data_o,
  input  logic                  host_req_i,
  input  logic                  host_we_i,
  input  logic [ADDR_WIDTH-1:0] host_addr_i,
  input  logic [7:0]            host_data_i,
  output logic                  host_ack_o,
  output logic [7:0]            host_data_o,
  output logic [ADDR_WIDTH-1:0] ram_addr_o,
  output logic                  ram_rd_o,
  output logic                  ram_we_o,
  output logic [7:0]            ram_data_o,
  input  logic [7:0]            ram_data_i,
  output logic                  busy_o
);

  localparam int unsigned LAT_W = 3;
  localparam int unsigned HW_W  = 8;
  localparam logic [LAT_W-1:0] LAT_INIT = LAT_W'(RAM_LATENCY - 1);
  localparam logic [HW_W-1:0]  HW_MAX   = HW_W'(HOST_MAX_WAIT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_DONE} state_e;

  state_e                  state_q, state_d;
  logic                    doc_pend_q, doc_pend_d;
  logic [ADDR_WIDTH-1:0]   doc_addr_q, doc_addr_d;
  logic [HW_W-1:0]         hwait_q, hwait_d;
  logic [LAT_W-1:0]        lat_q, lat_d;
  logic                    cur_doc_q, cur_doc_d;
  logic                    cur_we_q, cur_we_d;
  logic [ADDR_WIDTH-1:0]   ram_addr_d;
  logic [7:0]              ram_data_d, doc_data_d, host_data_d;
  logic                    ram_rd_d, ram_we_d, doc_ready_d, host_ack_d, busy_d;

  logic                    idle, host_busy, host_pend, doc_avail, grant_doc, grant_host;
  logic [ADDR_WIDTH-1:0]   doc_addr_sel;

  // A host whose own access is in flight (including its ack cycle) is not competing.
  always_comb begin : arbitration
    idle         = (state_q == S_IDLE);
    host_busy    = !idle && !cur_doc_q;
    host_pend    = host_req_i && !host_busy;
    doc_avail    = doc_pend_q || doc_rd_i;
    doc_addr_sel = doc_rd_i ? doc_addr_i : doc_addr_q;
    grant_doc    = idle && doc_avail && (hwait_q < HW_MAX);
    grant_host   = idle && !grant_doc && host_pend;
  end

  always_ff @(posedge clk_i) begin : state_reg
    if (reset_i) state_q <= S_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin : next_state
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_doc || grant_host) state_d = S_ISSUE;
      S_ISSUE: state_d = cur_we_q ? S_DONE : S_WAIT;
      S_WAIT:  if (lat_q == '0) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Next values for every registered output and the request/latency bookkeeping.
  always_comb begin : output_next
    doc_pend_d  = doc_pend_q;
    doc_addr_d  = doc_addr_q;
    hwait_d     = hwait_q;
    lat_d       = lat_q;
    cur_doc_d   = cur_doc_q;
    cur_we_d    = cur_we_q;
    ram_addr_d  = ram_addr_o;
    ram_data_d  = ram_data_o;
    doc_data_d  = doc_data_o;
    host_data_d = host_data_o;
    ram_rd_d    = 1'b0;
    ram_we_d    = 1'b0;
    doc_ready_d = 1'b0;
    host_ack_d  = 1'b0;
    busy_d      = (state_d != S_IDLE);

    if (grant_doc)     doc_pend_d = 1'b0;
    else if (doc_rd_i) doc_pend_d = 1'b1;
    if (doc_rd_i)      doc_addr_d = doc_addr_i;

    if (!host_req_i || grant_host)          hwait_d = '0;
    else if (host_pend && hwait_q < HW_MAX) hwait_d = hwait_q + HW_W'(1);

    case (state_q)
      S_IDLE: begin
        if (grant_doc) begin
          cur_doc_d  = 1'b1;
          cur_we_d   = 1'b0;
          ram_addr_d = doc_addr_sel;
          ram_rd_d   = 1'b1;
        end else if (grant_host) begin
          cur_doc_d  = 1'b0;
          cur_we_d   = host_we_i;
          ram_addr_d = host_addr_i;
          ram_rd_d   = !host_we_i;
          ram_we_d   = host_we_i;
          if (host_we_i) ram_data_d = host_data_i;
        end
      end
      S_ISSUE: begin
        lat_d      = LAT_INIT;
        host_ack_d = cur_we_q;
      end
      S_WAIT: begin
        if (lat_q == '0) begin
          if (cur_doc_q) doc_data_d  = ram_data_i;
          else           host_data_d = ram_data_i;
          doc_ready_d = cur_doc_q;
          host_ack_d  = !cur_doc_q;
        end else begin
          lat_d = lat_q - LAT_W'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin : datapath_regs
    if (reset_i) begin
      doc_pend_q  <= 1'b0;
      doc_addr_q  <= '0;
      hwait_q     <= '0;
      lat_q       <= '0;
      cur_doc_q   <= 1'b0;
      cur_we_q    <= 1'b0;
      ram_addr_o  <= '0;
      ram_rd_o    <= 1'b0;
      ram_we_o    <= 1'b0;
      ram_data_o  <= '0;
      doc_ready_o <= 1'b0;
      doc_data_o  <= '0;
      host_ack_o  <= 1'b0;
      host_data_o <= '0;
      busy_o      <= 1'b0;
    end else begin
      doc_pend_q  <= doc_pend_d;
      doc_addr_q  <= doc_addr_d;
      hwait_q     <= hwait_d;
      lat_q       <= lat_d;
      cur_doc_q   <= cur_doc_d;
      cur_we_q    <= cur_we_d;
      ram_addr_o  <= ram_addr_d;
      ram_rd_o    <= ram_rd_d;
      ram_we_o    <= ram_we_d;
      ram_data_o  <= ram_data_d;
      doc_ready_o <= doc_ready_d;
      doc_data_o  <= doc_data_d;
      host_ack_o  <= host_ack_d;
      host_data_o <= host_data_d;
      busy_o      <= busy_d;
    end
  end

endmodule

// File: tb/tb_doc5503_wave_arbiter.sv
// Bench for doc5503_wave_arbiter: latency-accurate RAM, per-cycle access-timeline model, directed scenarios.
module tb_doc5503_wave_arbiter;

  localparam int unsigned AW  = 16;
  localparam int unsigned RL  = 2;
  localparam int unsigned HMW = 3;

  logic          clk_i = 1'b0;
  logic          reset_i = 1'b1;
  logic [AW-1:0] doc_addr_i = '0;
  logic          doc_rd_i = 1'b0;
  logic          doc_ready_o;
  logic [7:0]    doc_data_o;
  logic          host_req_i = 1'b0;
  logic          host_we_i = 1'b0;
  logic [AW-1:0] host_addr_i = '0;
  logic [7:0]    host_data_i = '0;
  logic          host_ack_o;
  logic [7:0]    host_data_o;
  logic [AW-1:0] ram_addr_o;
  logic          ram_rd_o;
  logic          ram_we_o;
  logic [7:0]    ram_data_o;
  logic [7:0]    ram_data_i;
  logic          busy_o;

  doc5503_wave_arbiter #(.ADDR_WIDTH(AW), .RAM_LATENCY(RL), .HOST_MAX_WAIT(HMW)) dut (
    .clk_i(clk_i), .reset_i(reset_i),
    .doc_addr_i(doc_addr_i), .doc_rd_i(doc_rd_i), .doc_ready_o(doc_ready_o), .doc_data_o(doc_data_o),
    .host_req_i(host_req_i), .host_we_i(host_we_i), .host_addr_i(host_addr_i), .host_data_i(host_data_i),
    .host_ack_o(host_ack_o), .host_data_o(host_data_o),
    .ram_addr_o(ram_addr_o), .ram_rd_o(ram_rd_o), .ram_we_o(ram_we_o), .ram_data_o(ram_data_o),
    .ram_data_i(ram_data_i), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Sound RAM: data appears exactly RL cycles after the read strobe, junk otherwise.
  logic [7:0]  mem [0:65535];
  logic [7:0]  m_mem [0:65535];
  logic [RL-1:0] pv;
  logic [AW-1:0] pa [RL];
  always @(posedge clk_i) begin
    pv <= {pv[RL-2:0], ram_rd_o};
    pa[0] <= ram_addr_o;
    for (int i = 1; i < RL; i++) pa[i] <= pa[i-1];
    if (ram_we_o) mem[ram_addr_o] <= ram_data_o;
  end
  assign ram_data_i = pv[RL-1] ? mem[pa[RL-1]] : 8'hEE;

  task automatic poke(input logic [AW-1:0] a, input logic [7:0] d);
    mem[a] = d;
    m_mem[a] = d;
  endtask

  // Model: each access occupies grant+1 .. grant+dur; dur is 2 for writes, RL+2 for reads.
  bit started = 1'b0;
  bit m_active, m_doc, m_we, dpend, idle_c, hp, gd, gh;
  int t, dur, hw;
  logic [AW-1:0] m_addr, daddr, exp_addr;
  logic [7:0] m_wd, exp_wd, exp_ddata, exp_hdata;
  bit exp_busy, exp_rd, exp_we, exp_rdy, exp_ack, chk_addr, chk_wd;

  initial forever begin
    @(posedge clk_i);
    cyc++;
    if (reset_i) begin
      started = 1'b1; m_active = 1'b0; dpend = 1'b0; hw = 0;
      exp_busy = 1'b0; exp_rd = 1'b0; exp_we = 1'b0; exp_rdy = 1'b0; exp_ack = 1'b0;
      exp_ddata = '0; exp_hdata = '0; exp_addr = '0; exp_wd = '0; chk_addr = 1'b1; chk_wd = 1'b1;
    end else begin
      idle_c = !m_active;
      hp = host_req_i && !(m_active && !m_doc);
      gd = idle_c && (dpend || doc_rd_i) && (hw < int'(HMW));
      gh = idle_c && !gd && hp;
      if (!host_req_i || gh) hw = 0;
      else if (hp && hw < int'(HMW)) hw++;
      if (m_active) begin
        if (t == dur) m_active = 1'b0;
        else t++;
      end
      if (gd) begin
        m_active = 1'b1; t = 1; m_doc = 1'b1; m_we = 1'b0;
        m_addr = doc_rd_i ? doc_addr_i : daddr; dur = RL + 2; dpend = 1'b0;
      end else if (doc_rd_i) begin
        dpend = 1'b1; daddr = doc_addr_i;
      end
      if (gh) begin
        m_active = 1'b1; t = 1; m_doc = 1'b0; m_we = host_we_i;
        m_addr = host_addr_i; m_wd = host_data_i; dur = host_we_i ? 2 : RL + 2;
      end
      exp_rd = 1'b0; exp_we = 1'b0; exp_rdy = 1'b0; exp_ack = 1'b0; chk_addr = 1'b0; chk_wd = 1'b0;
      exp_busy = m_active;
      if (m_active) begin
        if (t == 1) begin
          exp_rd = !m_we;
          exp_we = m_we;
          if (m_we) begin exp_wd = m_wd; chk_wd = 1'b1; m_mem[m_addr] = m_wd; end
        end
        if (t < dur) begin exp_addr = m_addr; chk_addr = 1'b1; end
        if (t == dur) begin
          if (m_doc) begin exp_rdy = 1'b1; exp_ddata = m_mem[m_addr]; end
          else begin exp_ack = 1'b1; if (!m_we) exp_hdata = m_mem[m_addr]; end
        end
      end
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clk_i);
    if (started) begin
      chk("busy", int'(busy_o), int'(exp_busy));
      chk("ram_rd", int'(ram_rd_o), int'(exp_rd));
      chk("ram_we", int'(ram_we_o), int'(exp_we));
      chk("doc_ready", int'(doc_ready_o), int'(exp_rdy));
      chk("host_ack", int'(host_ack_o), int'(exp_ack));
      chk("doc_data", int'(doc_data_o), int'(exp_ddata));
      chk("host_data", int'(host_data_o), int'(exp_hdata));
      if (chk_addr) chk("ram_addr", int'(ram_addr_o), int'(exp_addr));
      if (chk_wd)   chk("ram_wdata", int'(ram_data_o), int'(exp_wd));
    end
  end

  // Event log used by the directed checks.
  int n_ready = 0, n_ack = 0, last_ready_cyc = 0, last_we_cyc = 0;
  logic [7:0] last_ready_data = '0, last_we_data = '0;
  logic [AW-1:0] rd_log [$];
  int rd_cyc [$];
  initial forever begin
    @(negedge clk_i);
    if (doc_ready_o) begin n_ready++; last_ready_cyc = cyc; last_ready_data = doc_data_o; end
    if (host_ack_o) n_ack++;
    if (ram_rd_o) begin rd_log.push_back(ram_addr_o); rd_cyc.push_back(cyc); end
    if (ram_we_o) begin last_we_cyc = cyc; last_we_data = ram_data_o; end
  end

  task automatic step();
    @(negedge clk_i);
  endtask

  task automatic wait_ack(output int at, output logic [7:0] d);
    at = -1; d = '0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (host_ack_o) begin at = cyc; d = host_data_o; return; end
    end
    chk("ack_timeout", int'(host_ack_o), 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog expired");
  end

  int t0, t1, ta, tb, ka, rdn, r0, a0;
  logic [7:0] d;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      mem[i] = 8'(i * 7 + 3);
      m_mem[i] = 8'(i * 7 + 3);
    end
    poke(16'h1234, 8'h5A); poke(16'h0042, 8'h6B); poke(16'h0077, 8'h9E);
    poke(16'h0020, 8'h3D); poke(16'h0010, 8'h11); poke(16'h0400, 8'h81);

    repeat (3) step();
    reset_i = 1'b0;
    chk("rst_busy", int'(busy_o), 0);
    chk("rst_ddata", int'(doc_data_o), 0);
    chk("rst_addr", int'(ram_addr_o), 0);
    repeat (2) step();

    // DOC read from idle
    t0 = cyc; r0 = n_ready; a0 = n_ack; rdn = rd_log.size();
    doc_rd_i = 1'b1; doc_addr_i = 16'h1234;
    step(); doc_rd_i = 1'b0;
    repeat (7) step();
    chk("doc_ready_cnt", n_ready - r0, 1);
    chk("doc_ready_lat", last_ready_cyc - t0, 4);
    chk("doc_data_5a", int'(last_ready_data), 32'h5A);
    chk("doc_no_ack", n_ack - a0, 0);
    chk("doc_rd_cnt", rd_log.size() - rdn, 1);
    if (rd_log.size() > rdn) begin
      chk("doc_rd_lat", rd_cyc[rdn] - t0, 1);
      chk("doc_rd_addr", int'(rd_log[rdn]), 32'h1234);
    end

    // Host write then read-back with the request held across the ack
    step();
    t0 = cyc;
    host_req_i = 1'b1; host_we_i = 1'b1; host_addr_i = 16'h00FF; host_data_i = 8'hC3;
    wait_ack(ta, d);
    host_we_i = 1'b0; host_data_i = 8'h00;
    wait_ack(tb, d);
    host_req_i = 1'b0;
    chk("hw_ack_lat", ta - t0, 2);
    chk("hw_we_cyc", last_we_cyc - t0, 1);
    chk("hw_we_data", int'(last_we_data), 32'hC3);
    chk("hr_ack_lat", tb - ta, 5);
    chk("hr_data_c3", int'(d), 32'hC3);
    repeat (3) step();

    // Simultaneous DOC pulse and host request
    t0 = cyc; r0 = n_ready; a0 = n_ack;
    doc_rd_i = 1'b1; doc_addr_i = 16'h0042;
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 16'h0077;
    step(); doc_rd_i = 1'b0;
    wait_ack(ta, d);
    host_req_i = 1'b0;
    repeat (3) step();
    chk("sim_doc_lat", last_ready_cyc - t0, 4);
    chk("sim_doc_data", int'(last_ready_data), 32'h6B);
    chk("sim_host_lat", ta - t0, 9);
    chk("sim_host_data", int'(d), 32'h9E);
    chk("sim_ready_cnt", n_ready - r0, 1);
    chk("sim_ack_cnt", n_ack - a0, 1);

    // Starvation guard: DOC pulses every 4 cycles against a pending host read
    step();
    t0 = cyc; a0 = n_ack; rdn = rd_log.size(); ka = -1;
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 16'h0300;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) step();
      if (k > 0 && host_ack_o) begin ka = k; host_req_i = 1'b0; end
      doc_rd_i = ((k % 4) == 0) && (k <= 12);
      doc_addr_i = 16'h0100 + 16'(k / 4);
    end
    step(); doc_rd_i = 1'b0;
    chk("stv_ack_cyc", ka, 9);
    chk("stv_ack_cnt", n_ack - a0, 1);
    chk("stv_rd_cnt", rd_log.size() - rdn, 4);
    if (rd_log.size() >= rdn + 4) begin
      chk("stv_rd0", int'(rd_log[rdn]), 32'h0100);
      chk("stv_rd1_host", int'(rd_log[rdn+1]), 32'h0300);
      chk("stv_rd1_cyc", rd_cyc[rdn+1] - t0, 6);
      chk("stv_rd2", int'(rd_log[rdn+2]), 32'h0102);
      chk("stv_rd3", int'(rd_log[rdn+3]), 32'h0103);
    end
    repeat (3) step();

    // DOC overwrite while a host read is in its latency wait
    t0 = cyc; r0 = n_ready; rdn = rd_log.size(); ka = -1;
    host_req_i = 1'b1; host_we_i = 1'b0; host_addr_i = 16'h0400;
    for (int k = 0; k < 16; k++) begin
      if (k > 0) step();
      if (k > 0 && host_ack_o) begin ka = k; host_req_i = 1'b0; end
      doc_rd_i = (k == 2) || (k == 3);
      doc_addr_i = (k == 2) ? 16'h0010 : 16'h0020;
    end
    chk("ovw_ack_cyc", ka, 4);
    chk("ovw_rd_cnt", rd_log.size() - rdn, 2);
    if (rd_log.size() >= rdn + 2) chk("ovw_rd_addr", int'(rd_log[rdn+1]), 32'h0020);
    chk("ovw_ready_cnt", n_ready - r0, 1);
    chk("ovw_ready_lat", last_ready_cyc - t0, 9);
    chk("ovw_data", int'(last_ready_data), 32'h3D);
    repeat (2) step();

    // Reset during WAIT discards the access
    t0 = cyc; r0 = n_ready; a0 = n_ack;
    doc_rd_i = 1'b1; doc_addr_i = 16'h1234;
    step(); doc_rd_i = 1'b0;
    step(); reset_i = 1'b1;
    step(); reset_i = 1'b0;
    chk("mid_rst_busy", int'(busy_o), 0);
    chk("mid_rst_rd", int'(ram_rd_o), 0);
    chk("mid_rst_addr", int'(ram_addr_o), 0);
    chk("mid_rst_ddata", int'(doc_data_o), 0);
    chk("mid_rst_hdata", int'(host_data_o), 0);
    repeat (8) step();
    chk("mid_rst_no_ready", n_ready - r0, 0);
    chk("mid_rst_no_ack", n_ack - a0, 0);
    t1 = cyc;
    doc_rd_i = 1'b1; doc_addr_i = 16'h1234;
    step(); doc_rd_i = 1'b0;
    repeat (7) step();
    chk("post_rst_cnt", n_ready - r0, 1);
    chk("post_rst_lat", last_ready_cyc - t1, 4);
    chk("post_rst_data", int'(last_ready_data), 32'h5A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/doc5503_wave_arbiter.md
Name: doc5503_wave_arbiter

Overview:
- Shares the single 8-bit sound RAM between two requesters: the DOC5503 oscillator wave fetch port and the host access port (GLU RAM access with auto-increment, performed upstream).
- Owns the RAM control signals and sequences one access at a time through an issue/latency/complete FSM.
- DOC fetches take priority; a starvation guard bounds how long a host access can be delayed.
- Sits between doc5503 (wave_address_o/wave_rd_o/wave_data_ready_i/wave_data_i) and the sound RAM.

Parameters:
- ADDR_WIDTH, 16: sound RAM address width.
- RAM_LATENCY, 2: cycles from ram_rd_o to valid ram_data_i, range 1..7.
- HOST_MAX_WAIT, 8: number of cycles a pending host request may lose arbitration before it wins over a pending DOC request, range 1..255.

Ports:
- clk_i, in, 1: clock.
- reset_i, in, 1: synchronous active-high reset.
- doc_addr_i, in, ADDR_WIDTH: DOC wave address, sampled when doc_rd_i=1.
- doc_rd_i, in, 1: single-cycle DOC fetch request pulse.
- doc_ready_o, out, 1: one-cycle pulse; doc_data_o is valid in that cycle.
- doc_data_o, out, 8: fetched wave byte.
- host_req_i, in, 1: host request, level; held until host_ack_o.
- host_we_i, in, 1: 1 = write, 0 = read; sampled with host_req_i.
- host_addr_i, in, ADDR_WIDTH: host address.
- host_data_i, in, 8: host write data.
- host_ack_o, out, 1: one-cycle completion pulse.
- host_data_o, out, 8: host read data, valid when host_ack_o=1 for a read.
- ram_addr_o, out, ADDR_WIDTH: RAM address.
- ram_rd_o, out, 1: one-cycle RAM read strobe.
- ram_we_o, out, 1: one-cycle RAM write strobe.
- ram_data_o, out, 8: RAM write data.
- ram_data_i, in, 8: RAM read data.
- busy_o, out, 1: FSM not in IDLE.

Behaviour:
- Reset values: all outputs 0, FSM IDLE, doc_pend=0, wait counter 0. Reset has priority over every other event.
- Reset mid-operation discards the in-flight access and any latched DOC request. No doc_ready_o or host_ack_o is emitted for a discarded access.
- DOC request latch:
  - doc_rd_i=1 sets doc_pend and captures doc_addr_i into doc_addr_q.
  - A new pulse while doc_pend=1 overwrites doc_addr_q (latest address wins). Only one doc_ready_o is produced for it.
  - doc_pend clears in the cycle the DOC access is issued.
- Host pending means host_req_i=1 and the FSM is not currently completing a host access.
- Arbitration happens only in IDLE:
  - DOC wins if doc_pend=1 and hwait < HOST_MAX_WAIT.
  - Otherwise the host wins if pending.
  - A doc_rd_i pulse arriving in the same cycle as the IDLE decision counts as pending for that cycle (bypass).
- hwait counter:
  - Increments each IDLE cycle in which the host is pending but DOC is granted; saturates at HOST_MAX_WAIT.
  - Also increments each cycle the host is pending while the FSM is busy.
  - Clears when the host is granted, or when host_req_i=0.
- FSM states:
  - IDLE: on grant, drive ram_addr_o and go to ISSUE.
  - ISSUE (1 cycle):
    - Read (DOC or host): ram_rd_o=1; go to WAIT with lat counter = RAM_LATENCY-1.
    - Host write: ram_we_o=1, ram_data_o=host_data_i; go to DONE.
    - ram_addr_o is held from ISSUE through the capture cycle.
  - WAIT: decrement lat each cycle. When lat==0, capture ram_data_i into doc_data_o or host_data_o and go to DONE.
  - DONE (1 cycle): pulse doc_ready_o or host_ack_o; return to IDLE.
- Latency from grant to completion pulse:
  - Read: RAM_LATENCY+2 cycles.
  - Write: 2 cycles.
  - Minimum 1 IDLE cycle between accesses.
- Data outputs hold their last captured value until the next capture.
- Host protocol:
  - The host must drop host_req_i, or present a new request, in the cycle after host_ack_o.
  - The arbiter ignores host_req_i in the cycle host_ack_o=1, so a held request is not serviced twice.
  - Changing host_addr_i, host_we_i or host_data_i while the request is pending but not yet granted is legal; values are sampled at grant.
- ram_rd_o and ram_we_o are never both 1. At most one access is in flight.

Test Plan:
- DOC read: RAM model latency 2, mem[0x1234]=0x5A; pulse doc_rd_i with addr 0x1234 in IDLE -> ram_rd_o at cycle+1, doc_ready_o with doc_data_o=0x5A exactly 4 cycles after the pulse; host_ack_o stays 0.
- Host write then read: write 0xC3 to 0x00FF -> ram_we_o one cycle with ram_data_o=0xC3, host_ack_o 2 cycles after grant; then read 0x00FF -> host_data_o=0xC3 with host_ack_o.
- Simultaneous: doc_rd_i pulse and host_req_i rise in the same IDLE cycle -> DOC access completes first, host access is granted in the next IDLE; exactly one pulse each.
- Starvation: HOST_MAX_WAIT=3, host read pending while DOC pulses every 4 cycles -> host is granted no later than its 4th IDLE decision, ahead of a pending DOC request; DOC is serviced next; hwait returns to 0.
- DOC overwrite: two doc_rd_i pulses (0x0010, then 0x0020) while a host read is in WAIT -> a single DOC access to 0x0020, a single doc_ready_o.
- Reset mid-read: assert reset_i during WAIT -> next cycle all outputs 0, FSM IDLE, no doc_ready_o or host_ack_o; a fresh DOC request afterwards completes normally.
